xy_switch_rr: RTL and testbench

XY_SWITCH_RR -- requirements
Module: xy_switch_rr

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_fifo.sv | 54 +++++
 rtl/xy_switch_rr.sv | 137 +++++++++++++
 tb/tb_xy_switch_rr.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants for the mesh NoC: port numbering and packet field layout.
// Packets are laid out as {col, row, data} with the column in the MSBs.
package noc_pkg;

    localparam int PORT_CNT   = 5;

    localparam int PORT_RES   = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    localparam int PCKT_COL_ADDR_W_DEF = 4;
    localparam int PCKT_ROW_ADDR_W_DEF = 4;
    localparam int PCKT_DATA_W_DEF     = 8;

    localparam int PCKT_DATA_LSB = 0;

    // Row field sits directly above the data field.
    function automatic int pckt_row_lsb(input int data_w);
        return PCKT_DATA_LSB + data_w;
    endfunction

    // Column field sits above the row field.
    function automatic int pckt_col_lsb(input int data_w, input int row_w);
        return PCKT_DATA_LSB + data_w + row_w;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with combinational head output, full/empty flags and a
// one-cycle overflow pulse for every write dropped while full.
module noc_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];
    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                     (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign dout_o  = mem[rd_ptr[DEPTH_W-1:0]];

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en_i && !full_o;
    assign rd_ok = rd_en_i && !empty_o;

    // Pointer and overflow-flag control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            overflow_o <= wr_en_i && full_o;
        end
    end

    // Storage array; contents are don't-care once pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr[DEPTH_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/xy_switch_rr.sv
// Five-port XY-routing mesh switch. Each input is buffered in a noc_fifo;
// each output runs a round-robin arbiter over inputs whose head packet
// routes to it. Grant/pop happens in stage p0, the packet is registered and
// presented on the output in stage p1.
module xy_switch_rr
    import noc_pkg::*;
#(
    parameter int COL_CORD        = 0,
    parameter int ROW_CORD        = 0,
    parameter int PORT_N          = PORT_CNT,
    parameter int IN_FIFO_DEPTH_W = 3,
    parameter int PCKT_COL_ADDR_W = PCKT_COL_ADDR_W_DEF,
    parameter int PCKT_ROW_ADDR_W = PCKT_ROW_ADDR_W_DEF,
    parameter int PCKT_DATA_W     = PCKT_DATA_W_DEF,
    parameter int PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PORT_N-1:0]        wr_en_sw_i,
    input  logic [PCKT_W*PORT_N-1:0] pckt_sw_i,
    output logic [PORT_N-1:0]        in_fifo_full_o,
    output logic [PORT_N-1:0]        in_fifo_overflow_o,
    input  logic [PORT_N-1:0]        nxt_fifo_full_i,
    input  logic [PORT_N-1:0]        nxt_fifo_overflow_i,
    output logic [PORT_N-1:0]        wr_en_sw_o,
    output logic [PCKT_W*PORT_N-1:0] pckt_sw_o,
    output logic [PORT_N-1:0]        err_o
);

    localparam int ROW_LSB = pckt_row_lsb(PCKT_DATA_W);
    localparam int COL_LSB = pckt_col_lsb(PCKT_DATA_W, PCKT_ROW_ADDR_W);
    localparam logic [PCKT_COL_ADDR_W-1:0] MY_COL = PCKT_COL_ADDR_W'(COL_CORD);
    localparam logic [PCKT_ROW_ADDR_W-1:0] MY_ROW = PCKT_ROW_ADDR_W'(ROW_CORD);

    logic [PCKT_W-1:0] head_p0    [PORT_N];
    logic [2:0]        dest_p0    [PORT_N];
    logic [2:0]        gnt_idx_p0 [PORT_N];
    logic [2:0]        ptr_q      [PORT_N];
    logic [2:0]        ptr_nxt    [PORT_N];
    logic [PCKT_W-1:0] pckt_p1    [PORT_N];
    logic [PORT_N-1:0] empty_p0;
    logic [PORT_N-1:0] gnt_vld_p0;
    logic [PORT_N-1:0] pop_p0;
    logic [PORT_N-1:0] vld_p1;
    logic [PORT_N-1:0] err_q;

    // Dimension-ordered routing: resolve the column first, then the row.
    function automatic logic [2:0] xy_route(input logic [PCKT_W-1:0] pckt);
        logic [PCKT_COL_ADDR_W-1:0] col;
        logic [PCKT_ROW_ADDR_W-1:0] row;
        col = pckt[COL_LSB +: PCKT_COL_ADDR_W];
        row = pckt[ROW_LSB +: PCKT_ROW_ADDR_W];
        if (col > MY_COL)      return 3'(PORT_EAST);
        else if (col < MY_COL) return 3'(PORT_WEST);
        else if (row > MY_ROW) return 3'(PORT_SOUTH);
        else if (row < MY_ROW) return 3'(PORT_NORTH);
        else                   return 3'(PORT_RES);
    endfunction

    for (genvar p = 0; p < PORT_N; p++) begin : g_port
        noc_fifo #(
            .WIDTH   (PCKT_W),
            .DEPTH_W (IN_FIFO_DEPTH_W)
        ) u_in_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_en_i    (wr_en_sw_i[p]),
            .din_i      (pckt_sw_i[p*PCKT_W +: PCKT_W]),
            .rd_en_i    (pop_p0[p]),
            .dout_o     (head_p0[p]),
            .full_o     (in_fifo_full_o[p]),
            .empty_o    (empty_p0[p]),
            .overflow_o (in_fifo_overflow_o[p])
        );

        assign dest_p0[p]                      = xy_route(head_p0[p]);
        assign pckt_sw_o[p*PCKT_W +: PCKT_W]   = pckt_p1[p];
    end

    // ---- stage p0: per-output round-robin search starting at the pointer
    always_comb begin
        int         idx;
        logic       found;
        logic [2:0] win;
        idx = 0;
        for (int o = 0; o < PORT_N; o++) begin
            found = 1'b0;
            win   = '0;
            for (int i = 0; i < PORT_N; i++) begin
                idx = int'(ptr_q[o]) + i;
                if (idx >= PORT_N) idx = idx - PORT_N;
                if (!found && !empty_p0[idx] && !nxt_fifo_full_i[o] &&
                    dest_p0[idx] == 3'(o)) begin
                    found = 1'b1;
                    win   = 3'(idx);
                end
            end
            gnt_vld_p0[o] = found;
            gnt_idx_p0[o] = win;
            if (found) ptr_nxt[o] = (win == 3'(PORT_N - 1)) ? 3'd0 : win + 3'd1;
            else       ptr_nxt[o] = ptr_q[o];
        end
    end

    // Pop an input when any output grants it; an input routes to only one output.
    always_comb begin
        pop_p0 = '0;
        for (int p = 0; p < PORT_N; p++) begin
            for (int o = 0; o < PORT_N; o++) begin
                if (gnt_vld_p0[o] && gnt_idx_p0[o] == 3'(p)) pop_p0[p] = 1'b1;
            end
        end
    end

    // ---- stage p1: register granted packets, pointers and sticky errors
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= '0;
            err_q  <= '0;
            for (int o = 0; o < PORT_N; o++) begin
                ptr_q[o]   <= '0;
                pckt_p1[o] <= '0;
            end
        end else begin
            vld_p1 <= gnt_vld_p0;
            err_q  <= err_q | nxt_fifo_overflow_i;
            for (int o = 0; o < PORT_N; o++) begin
                ptr_q[o] <= ptr_nxt[o];
                if (gnt_vld_p0[o]) pckt_p1[o] <= head_p0[gnt_idx_p0[o]];
            end
        end
    end

    assign wr_en_sw_o = vld_p1;
    assign err_o      = err_q;

endmodule

// File: tb/tb_xy_switch_rr.sv
// Directed bench for xy_switch_rr at mesh position (1,1). Expected output
// packets are queued per output when stimulus is driven and retired when the
// switch emits them; idle outputs must hold their last packet.
module tb_xy_switch_rr;

    localparam int PW = 16;
    localparam int PN = 5;

    typedef struct {
        logic [PW-1:0] pckt;
        int            cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PN-1:0]    wr_en_sw_i;
    logic [PW*PN-1:0] pckt_sw_i;
    logic [PN-1:0]    in_fifo_full_o;
    logic [PN-1:0]    in_fifo_overflow_o;
    logic [PN-1:0]    nxt_fifo_full_i;
    logic [PN-1:0]    nxt_fifo_overflow_i;
    logic [PN-1:0]    wr_en_sw_o;
    logic [PW*PN-1:0] pckt_sw_o;
    logic [PN-1:0]    err_o;

    exp_t          sb [PN][$];
    logic [PW-1:0] last_pckt [PN];
    int            cyc    = 0;
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    xy_switch_rr #(
        .COL_CORD (1),
        .ROW_CORD (1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .wr_en_sw_i          (wr_en_sw_i),
        .pckt_sw_i           (pckt_sw_i),
        .in_fifo_full_o      (in_fifo_full_o),
        .in_fifo_overflow_o  (in_fifo_overflow_o),
        .nxt_fifo_full_i     (nxt_fifo_full_i),
        .nxt_fifo_overflow_i (nxt_fifo_overflow_i),
        .wr_en_sw_o          (wr_en_sw_o),
        .pckt_sw_o           (pckt_sw_o),
        .err_o               (err_o)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input int o, input logic [PW-1:0] p, input int c);
        exp_t e;
        e.pckt = p;
        e.cyc  = c;
        sb[o].push_back(e);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        for (int o = 0; o < PN; o++) begin
            if (wr_en_sw_o[o]) begin
                chk($sformatf("out%0d_expected", o), 80'(sb[o].size() != 0), 80'(1));
                if (sb[o].size() != 0) begin
                    e = sb[o].pop_front();
                    chk($sformatf("out%0d_pckt", o), 80'(pckt_sw_o[o*PW +: PW]), 80'(e.pckt));
                    if (e.cyc >= 0)
                        chk($sformatf("out%0d_cycle", o), 80'(cyc), 80'(e.cyc));
                    last_pckt[o] = e.pckt;
                end
            end else begin
                chk($sformatf("out%0d_hold", o), 80'(pckt_sw_o[o*PW +: PW]), 80'(last_pckt[o]));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int o = 0; o < PN; o++) begin
            sb[o].delete();
            last_pckt[o] = '0;
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int p, input logic [PW-1:0] v);
        wr_en_sw_i[p]           = 1'b1;
        pckt_sw_i[p*PW +: PW]   = v;
    endtask

    // Run until every expected packet is retired or the budget expires.
    task automatic drain(input string tag, input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < budget) begin
            tick();
            n++;
            pend = 0;
            for (int o = 0; o < PN; o++) pend += sb[o].size();
        end
        for (int o = 0; o < PN; o++)
            chk($sformatf("%s_pending%0d", tag, o), 80'(sb[o].size()), 80'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst                 = 1'b1;
        wr_en_sw_i          = '0;
        pckt_sw_i           = '0;
        nxt_fifo_full_i     = '0;
        nxt_fifo_overflow_i = '0;
        do_reset();

        // Reset state
        chk("rst_wr_en",    80'(wr_en_sw_o),         80'(0));
        chk("rst_pckt",     80'(pckt_sw_o),          80'(0));
        chk("rst_full",     80'(in_fifo_full_o),     80'(0));
        chk("rst_overflow", 80'(in_fifo_overflow_o), 80'(0));
        chk("rst_err",      80'(err_o),              80'(0));

        // Resource -> East, two-cycle latency
        drive(0, 16'h21AA);
        push(2, 16'h21AA, cyc + 2);
        tick();
        wr_en_sw_i = '0;
        drain("east", 10);

        // Three concurrent transfers to distinct outputs
        do_reset();
        drive(1, 16'h0155);
        drive(4, 16'h1211);
        drive(2, 16'h1133);
        push(4, 16'h0155, cyc + 2);
        push(3, 16'h1211, cyc + 2);
        push(0, 16'h1133, cyc + 2);
        tick();
        wr_en_sw_i = '0;
        drain("concurrent", 10);

        // Round-robin contention on the Resource output
        do_reset();
        drive(1, 16'h1101);
        drive(3, 16'h1103);
        drive(4, 16'h1104);
        push(0, 16'h1101, cyc + 2);
        push(0, 16'h1103, cyc + 3);
        push(0, 16'h1104, cyc + 4);
        tick();
        wr_en_sw_i = '0;
        drain("rr", 10);

        // Backpressure: fill FIFO 0, overflow on the ninth write, then drain
        do_reset();
        nxt_fifo_full_i[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("fifo_full_before_9th", 80'(in_fifo_full_o[0]), 80'(1));
            drive(0, 16'h2000 + 16'(i));
            if (i < 8) push(2, 16'h2000 + 16'(i), -1);
            tick();
            chk($sformatf("overflow_w%0d", i), 80'(in_fifo_overflow_o[0]), 80'(i == 8));
        end
        wr_en_sw_i = '0;
        tick();
        chk("overflow_one_pulse", 80'(in_fifo_overflow_o[0]), 80'(0));
        chk("fifo_full_held",     80'(in_fifo_full_o[0]),     80'(1));
        nxt_fifo_full_i = '0;
        drain("release", 20);
        chk("fifo_full_after_drain", 80'(in_fifo_full_o[0]), 80'(0));

        // Sticky downstream overflow
        do_reset();
        nxt_fifo_overflow_i[3] = 1'b1;
        tick();
        nxt_fifo_overflow_i = '0;
        chk("err_set", 80'(err_o), 80'(5'b01000));
        repeat (5) tick();
        chk("err_sticky", 80'(err_o), 80'(5'b01000));
        do_reset();
        chk("err_cleared", 80'(err_o), 80'(0));

        // Reset with buffered packets and a write during reset
        nxt_fifo_full_i = '1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h2050 + 16'(i));
            tick();
        end
        wr_en_sw_i = '0;
        drive(1, 16'h1177);
        rst = 1'b1;
        for (int o = 0; o < PN; o++) begin
            sb[o].delete();
            last_pckt[o] = '0;
        end
        tick();
        rst             = 1'b0;
        wr_en_sw_i      = '0;
        nxt_fifo_full_i = '0;
        chk("post_rst_full",  80'(in_fifo_full_o), 80'(0));
        chk("post_rst_wr_en", 80'(wr_en_sw_o),     80'(0));
        repeat (10) tick();
        chk("post_rst_quiet", 80'(wr_en_sw_o), 80'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
